// File: rtl/gemv_sched_pkg.sv
// Shared types and helpers for the GEMV layer scheduler: FSM state encoding,
// index-width helper and default sizing.
package gemv_sched_pkg;

  localparam int DEFAULT_MAX_LAYERS     = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE,
    S_FAIL
  } state_t;

  // Width of an index into n entries; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gemv_layer_scheduler_if.sv
// Scheduler-to-engine link: launch pulse, bank select and input vector out,
// completion pulse and result vector back.
interface gemv_layer_scheduler_if
  import gemv_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 128,
  parameter int MAX_LAYERS = DEFAULT_MAX_LAYERS
);

  localparam int LW = idx_width(MAX_LAYERS);

  logic                                 eng_start;
  logic [LW-1:0]                        eng_layer;
  logic [0:VEC_LEN-1][DATA_WIDTH-1:0]   eng_x;
  logic                                 eng_done;
  logic [0:VEC_LEN-1][DATA_WIDTH-1:0]   eng_y;

  modport master (
    output eng_start, eng_layer, eng_x,
    input  eng_done, eng_y
  );

  modport slave (
    input  eng_start, eng_layer, eng_x,
    output eng_done, eng_y
  );

endinterface

// File: rtl/gemv_layer_scheduler_relu_vector.sv
// Per-element ReLU on a vector of signed values: a pure sign test that zeroes
// negative elements when enabled, with no saturation or rescaling.
module relu_vector #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 128
) (
  input  logic                               enable,
  input  logic [0:VEC_LEN-1][DATA_WIDTH-1:0] din,
  output logic [0:VEC_LEN-1][DATA_WIDTH-1:0] dout
);

  always_comb begin
    // NOTE: dout gets a full default before the conditional clamp so no path leaves it unassigned (no latch).
    dout = din;
    for (int i = 0; i < VEC_LEN; i++) begin
      if (enable && din[i][DATA_WIDTH-1]) dout[i] = '0;
    end
  end

endmodule

// File: rtl/gemv_layer_scheduler.sv
// Runs one GEMV engine through an N-layer MLP pass, feeding each layer's
// (optionally ReLU-clamped) result back as the next layer's input.
module gemv_layer_scheduler
  import gemv_sched_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int VEC_LEN        = 128,
  parameter int MAX_LAYERS     = DEFAULT_MAX_LAYERS,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [$clog2(MAX_LAYERS+1)-1:0]       num_layers,
  input  logic [MAX_LAYERS-1:0]                 relu_mask,
  input  logic [0:VEC_LEN-1][DATA_WIDTH-1:0]    x_in,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  error,
  output logic [0:VEC_LEN-1][DATA_WIDTH-1:0]    y_out,
  output logic [idx_width(MAX_LAYERS)-1:0]      layer_idx,
  gemv_layer_scheduler_if.master                eng
);

  localparam int LW  = idx_width(MAX_LAYERS);
  localparam int NLW = $clog2(MAX_LAYERS + 1);
  localparam int WDW = idx_width(TIMEOUT_CYCLES);

  typedef logic [0:VEC_LEN-1][DATA_WIDTH-1:0] vec_t;

  state_t           state;
  vec_t             buffer;
  vec_t             relu_y;
  logic [NLW-1:0]   num_q;
  logic [MAX_LAYERS-1:0] mask_q;
  logic [WDW-1:0]   watchdog;
  logic             eng_start_q;
  logic             relu_en;
  logic             last_layer;
  logic             bad_count;
  logic [NLW-1:0]   layer_next;

  assign relu_en    = mask_q[layer_idx];
  assign layer_next = NLW'(layer_idx) + NLW'(1);
  assign last_layer = (layer_next == num_q);
  assign bad_count  = (num_layers == '0) || (int'(num_layers) > MAX_LAYERS);

  // The buffer feeds the engine directly, so eng_x only moves at start or eng_done.
  assign eng.eng_start = eng_start_q;
  assign eng.eng_layer = layer_idx;
  assign eng.eng_x     = buffer;

  relu_vector #(
    .DATA_WIDTH (DATA_WIDTH),
    .VEC_LEN    (VEC_LEN)
  ) u_relu (
    .enable (relu_en),
    .din    (eng.eng_y),
    .dout   (relu_y)
  );

  // NOTE: all state uses non-blocking assignments so every branch sees start-of-cycle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      eng_start_q <= 1'b0;
      layer_idx   <= '0;
      num_q       <= '0;
      mask_q      <= '0;
      watchdog    <= '0;
      // NOTE: the vector registers are flops, not RAM, so resetting them is legal and keeps eng_x defined.
      y_out       <= '0;
      buffer      <= '0;
    end else begin
      eng_start_q <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            buffer    <= x_in;
            num_q     <= num_layers;
            mask_q    <= relu_mask;
            layer_idx <= '0;
            busy      <= 1'b1;
            if (bad_count) begin
              state <= S_FAIL;
              error <= 1'b1;
              done  <= 1'b1;
            end else begin
              state       <= S_LAUNCH;
              error       <= 1'b0;
              eng_start_q <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          watchdog <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // A completion arriving on the timeout cycle still counts as success.
          if (eng.eng_done) begin
            buffer <= relu_y;
            if (last_layer) begin
              y_out <= relu_y;
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              layer_idx   <= layer_idx + LW'(1);
              state       <= S_LAUNCH;
              eng_start_q <= 1'b1;
            end
          end else if (watchdog == WDW'(TIMEOUT_CYCLES - 1)) begin
            state <= S_FAIL;
            error <= 1'b1;
            done  <= 1'b1;
          end else begin
            watchdog <= watchdog + WDW'(1);
          end
        end
        S_DONE, S_FAIL: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
